// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and constants for the bit-serial add/subtract sequencer
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;
  localparam int CNT_W         = $clog2(DEFAULT_WIDTH);

  // Bit-counter width for an arbitrary operand width.
  function automatic int cnt_width(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/universal_full_adder_nand_overflow.sv
// rtl/universal_full_adder_nand_overflow.sv - 1-bit full adder built purely from 2-input NANDs
module universal_full_adder_nand_overflow (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s,
  output logic o_cout,
  output logic o_ovf
);

  logic w_n1, w_n2, w_n3, w_x1;
  logic w_n4, w_n5, w_n6;
  logic w_m1, w_m2, w_m3;

  // Sum = (a ^ b) ^ cin; the shared NAND terms also produce the carry.
  assign w_n1   = ~(i_a & i_b);
  assign w_n2   = ~(i_a & w_n1);
  assign w_n3   = ~(i_b & w_n1);
  assign w_x1   = ~(w_n2 & w_n3);
  assign w_n4   = ~(w_x1 & i_cin);
  assign w_n5   = ~(w_x1 & w_n4);
  assign w_n6   = ~(i_cin & w_n4);
  assign o_s    = ~(w_n5 & w_n6);
  assign o_cout = ~(w_n1 & w_n4);

  // Signed overflow when this cell sits at the MSB: carry-in XOR carry-out.
  assign w_m1   = ~(i_cin & o_cout);
  assign w_m2   = ~(i_cin & w_m1);
  assign w_m3   = ~(o_cout & w_m1);
  assign o_ovf  = ~(w_m2 & w_m3);

endmodule

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - LSB-first bit-serial add/subtract sequencer around one NAND full-adder cell
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int                  CNT_BITS = cnt_width(WIDTH);
  localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(WIDTH - 1);

  state_t              r_state;
  logic [WIDTH-1:0]    r_a;
  logic [WIDTH-1:0]    r_b;
  logic [WIDTH-1:0]    r_res;
  logic [CNT_BITS-1:0] r_cnt;
  logic                r_carry;
  logic                r_busy;
  logic                r_done;
  logic [WIDTH-1:0]    r_sum;
  logic                r_cout;
  logic                r_ovf;

  logic w_cell_s;
  logic w_cell_cout;
  logic w_cell_ovf;

  universal_full_adder_nand_overflow u_cell (
    .i_a    (r_a[0]),
    .i_b    (r_b[0]),
    .i_cin  (r_carry),
    .o_s    (w_cell_s),
    .o_cout (w_cell_cout),
    .o_ovf  (w_cell_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (start) begin
            // Subtraction is a + ~b + 1: invert B now and seed the carry with 1.
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_res   <= {w_cell_s, r_res[WIDTH-1:1]};
          r_carry <= w_cell_cout;
          if (r_cnt == LAST_CNT) begin
            // Visible results only change here, so they hold through a back-to-back op.
            r_sum   <= {w_cell_s, r_res[WIDTH-1:1]};
            r_cout  <= w_cell_cout;
            r_ovf   <= w_cell_ovf;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign sum      = r_sum;
  assign cout     = r_cout;
  assign overflow = r_ovf;

endmodule
